// File: rtl/wishbone_initiator.sv
// Wishbone classic single-transfer initiator.
// Accepts one command on a valid/ready handshake, runs one Wishbone bus cycle,
// and returns the result on a valid/ready response channel. A bus cycle with no
// ack is aborted after TIMEOUT strobe cycles and reported with rsp_err set.
// Ports:
//   wb_clk_i, wb_rst_i             clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_we/cmd_adr/cmd_dat/cmd_sel command fields
//   rsp_valid/rsp_ready            response handshake
//   rsp_dat/rsp_err                read data (0 for writes/errors), timeout flag
//   wbm_*_o                        Wishbone master request
//   wbm_ack_i, wbm_dat_i           Wishbone slave response
module wishbone_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  // Counter value seen on the last strobe cycle before the abort.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] wait_cnt_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      wait_cnt_q <= 8'd0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= 32'd0;
      rsp_err    <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= 4'd0;
      wbm_adr_o  <= 32'd0;
      wbm_dat_o  <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            wbm_we_o   <= cmd_we;
            wbm_adr_o  <= cmd_adr;
            wbm_dat_o  <= cmd_dat;
            wbm_sel_o  <= cmd_sel;
            wbm_cyc_o  <= 1'b1;
            wbm_stb_o  <= 1'b1;
            wait_cnt_q <= 8'd0;
            cmd_ready  <= 1'b0;
            state_q    <= StBus;
          end else begin
            // Also raises ready on the first cycle after reset release.
            cmd_ready <= 1'b1;
          end
        end
        StBus: begin
          // Ack is tested first so it wins over a simultaneous timeout.
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else if (wait_cnt_q == WaitLast) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/wishbone_initiator.md
WISHBONE_INITIATOR -- requirements
Module: wishbone_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum number of cycles a bus cycle waits for ack before abort; legal range 1..255.
REQ-002 SHALL have port wb_clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port cmd_valid, input, 1, command request present.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid and cmd_ready are both high at a clock edge.
REQ-006 SHALL have ports cmd_we (input, 1, write when 1), cmd_adr (input, 32, address), cmd_dat (input, 32, write data) and cmd_sel (input, 4, byte select).
REQ-007 SHALL have port rsp_valid, output, 1, response present.
REQ-008 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid and rsp_ready are both high at a clock edge.
REQ-009 SHALL have ports rsp_dat (output, 32, read data, or 0 for writes and errors) and rsp_err (output, 1, timeout abort).
REQ-010 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o (output, 1 each), wbm_sel_o (output, 4), wbm_adr_o (output, 32) and wbm_dat_o (output, 32), the Wishbone master request.
REQ-011 SHALL have ports wbm_ack_i (input, 1) and wbm_dat_i (input, 32), the Wishbone slave response.

Function
REQ-012 SHALL implement the states IDLE, BUS and RESP, with every output driven from registers.
REQ-013 SHALL drive cmd_ready high in IDLE only.
REQ-014 SHALL, in IDLE when a command is accepted, on the same edge: latch we, adr, dat and sel onto the wbm_* outputs; set wbm_cyc_o and wbm_stb_o to 1; clear the wait counter; and enter BUS, so the bus request is visible one cycle after acceptance.
REQ-015 SHALL, in BUS, hold wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o stable until the cycle ends.
REQ-016 SHALL, in BUS when wbm_ack_i is sampled high at an edge: clear wbm_cyc_o and wbm_stb_o; set rsp_dat to wbm_dat_i for a read or 0 for a write; set rsp_err to 0; set rsp_valid to 1; and enter RESP.
REQ-017 SHALL end a single-cycle acknowledged transaction with stb high for exactly one cycle.
REQ-018 SHALL, in BUS without ack, increment the 8-bit wait counter each cycle.
REQ-019 SHALL, when the counter equals TIMEOUT-1 with no ack: clear wbm_cyc_o and wbm_stb_o; set rsp_dat to 0; set rsp_err to 1; set rsp_valid to 1; and enter RESP, giving a total of TIMEOUT cycles with stb high.
REQ-020 SHALL give ack priority over timeout when both occur on the same edge, producing a normal response.
REQ-021 SHALL ignore wbm_ack_i in IDLE and RESP, with no state or output change.
REQ-022 SHALL, in RESP, hold rsp_valid, rsp_dat and rsp_err stable until rsp_ready is sampled high.
REQ-023 SHALL, on that rsp_ready edge, clear rsp_valid and return to IDLE, so cmd_ready is high on the next cycle and back-to-back commands issue every 3 cycles minimum for zero-wait slaves.
REQ-024 SHALL keep rsp_ready high in IDLE or BUS with no effect.
REQ-025 SHALL keep cmd_valid while not in IDLE with no effect; the command is not queued.
REQ-026 SHALL ignore cmd_sel for reads and pass it through to wbm_sel_o unchanged.

Reset
REQ-027 SHALL, on wb_rst_i high, immediately and without a clock: enter IDLE; drive all wbm_* outputs, rsp_valid, rsp_dat, rsp_err and the counter to 0; and drive cmd_ready to 0 while reset is asserted, then to 1 from the first cycle after release.
REQ-028 SHALL, on reset during BUS, drop wbm_cyc_o and wbm_stb_o asynchronously, abandon the transaction and produce no response.
REQ-029 SHALL, on reset during RESP, discard the pending response.

Verification
REQ-030 SHALL be verified by: write cmd_adr=0x00FF00FF, cmd_dat=0x00000002, cmd_sel=0x1; slave acks on the 2nd stb cycle -> wbm_we_o=1 and wbm_adr_o=0x00FF00FF during BUS, stb high 2 cycles, then rsp_valid=1, rsp_err=0, rsp_dat=0.
REQ-031 SHALL be verified by: read 0x00FF00FF; slave returns 0x00000002 with ack on the 1st cycle -> rsp_dat=0x00000002, rsp_err=0, stb high exactly 1 cycle.
REQ-032 SHALL be verified by: TIMEOUT=16 with no ack ever -> stb high exactly 16 cycles, then rsp_valid=1, rsp_err=1, rsp_dat=0.
REQ-033 SHALL be verified by: rsp_ready held low 5 cycles after a response -> rsp_* stable for 5 cycles and cmd_ready=0 throughout; stray ack pulses cause no change.
REQ-034 SHALL be verified by: wb_rst_i asserted mid-BUS between clock edges -> wbm_cyc_o and wbm_stb_o fall before the next edge, no rsp_valid, and a new command is accepted after release.
REQ-035 SHALL be verified by: ack arriving on the same edge as the timeout expiry (counter at 15, TIMEOUT=16) -> normal response with rsp_err=0 and captured data.
